// File: rtl/bsg_strobe_sched_pkg.sv
// bsg_strobe_sched_pkg: shared defaults and types for the multi-channel strobe scheduler.
package bsg_strobe_sched_pkg;
    localparam int els_default   = 4;
    localparam int width_default = 16;
    typedef logic [$clog2(els_default)-1:0] chan_id_t;
    typedef struct packed {
        logic                     en;
        logic [width_default-1:0] period;
    } chan_cfg_s;
endpackage

// File: rtl/bsg_strobe_sched_if.sv
// bsg_strobe_sched_if: config bus plus valid/yumi token handshake of the strobe scheduler.
interface bsg_strobe_sched_if #(
    parameter int els_p   = bsg_strobe_sched_pkg::els_default,
    parameter int width_p = bsg_strobe_sched_pkg::width_default
);
    localparam int lg_els_lp = $clog2(els_p);
    logic                 cfg_v_i;
    logic [lg_els_lp-1:0] cfg_id_i;
    logic                 cfg_en_i;
    logic [width_p-1:0]   cfg_period_i;
    logic                 v_o;
    logic [lg_els_lp-1:0] id_o;
    logic                 yumi_i;
    logic [els_p-1:0]     miss_o;
    modport master (output cfg_v_i, cfg_id_i, cfg_en_i, cfg_period_i, yumi_i, input v_o, id_o, miss_o);
    modport slave  (input cfg_v_i, cfg_id_i, cfg_en_i, cfg_period_i, yumi_i, output v_o, id_o, miss_o);
endinterface

// File: rtl/bsg_strobe_sched_chan.sv
// bsg_strobe_sched_chan: one programmable-period strobe counter with a single pending token and sticky miss flag.
// cfg is laid out as {en, period}, the same packing as chan_cfg_s.
module bsg_strobe_sched_chan import bsg_strobe_sched_pkg::*; #(
    parameter int width_p = width_default
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             cfg_we,
    input  logic [width_p:0] cfg,
    input  logic             grant,
    output logic             pending,
    output logic             miss
);
    logic               en_r, pending_r, miss_r, expire;
    logic [width_p-1:0] period_r, count_r;
    assign expire  = en_r && count_r == '0;
    assign pending = pending_r;
    assign miss    = miss_r;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_r      <= 1'b0;
            period_r  <= '0;
            count_r   <= '0;
            pending_r <= 1'b0;
            miss_r    <= 1'b0;
        end else if (cfg_we) begin
            en_r      <= cfg[width_p];
            period_r  <= cfg[width_p-1:0];
            count_r   <= cfg[width_p-1:0];
            pending_r <= 1'b0;
            miss_r    <= 1'b0;
        end else begin
            if (en_r) count_r <= expire ? period_r : count_r - 1'b1;
            // a yielded token is immediately replaced by a same-cycle expiry, so that case is not a miss
            pending_r <= expire | (pending_r & ~grant);
            miss_r    <= miss_r | (expire & pending_r & ~grant);
        end
    end
endmodule

// File: rtl/bsg_strobe_sched.sv
// bsg_strobe_sched: els_p strobe channels feeding one valid/yumi token port, round-robin arbitrated.
// Define BSG_STROBE_SCHED_FIXED_PRIO_EN for fixed priority (lowest pending id wins, no pointer).
module bsg_strobe_sched import bsg_strobe_sched_pkg::*; #(
    parameter int els_p   = els_default,
    parameter int width_p = width_default
) (
    input logic              clk_i,
    input logic              reset_n_i,
    bsg_strobe_sched_if.slave bus
);
    localparam int lg_els_lp = $clog2(els_p);
    logic [els_p-1:0]     pending, miss, grant, cfg_we;
    logic [lg_els_lp-1:0] id, j;
    logic                 v;
    assign v          = |pending;
    assign bus.v_o    = v;
    assign bus.id_o   = id;
    assign bus.miss_o = miss;
    for (genvar i = 0; i < els_p; i++) begin : g_chan
        assign cfg_we[i] = bus.cfg_v_i && bus.cfg_id_i == lg_els_lp'(i);
        assign grant[i]  = bus.yumi_i && v && id == lg_els_lp'(i);
        bsg_strobe_sched_chan #(.width_p(width_p)) chan (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .cfg_we   (cfg_we[i]),
            .cfg      ({bus.cfg_en_i, bus.cfg_period_i}),
            .grant    (grant[i]),
            .pending  (pending[i]),
            .miss     (miss[i])
        );
    end
`ifdef BSG_STROBE_SCHED_FIXED_PRIO_EN
    always_comb begin
        id = '0;
        j  = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            j = lg_els_lp'(k);
            if (pending[j]) id = j;
        end
    end
`else
    logic [lg_els_lp-1:0] rr_ptr_r;
    // scan downward from the farthest slot so the last hit is the first pending at or after rr_ptr_r
    always_comb begin
        id = '0;
        j  = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            j = lg_els_lp'((int'(rr_ptr_r) + k) % els_p);
            if (pending[j]) id = j;
        end
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rr_ptr_r <= '0;
        else if (bus.yumi_i && v) rr_ptr_r <= id == lg_els_lp'(els_p - 1) ? '0 : id + 1'b1;
    end
`endif
endmodule
